fifo_write_controller: RTL and testbench

FIFO_WRITE_CONTROLLER -- requirements
Module: fifo_write_controller

---
 rtl/fifo_write_controller.sv | 51 +++++
 tb/tb_fifo_write_controller.sv | 113 +++++++++++
 2 files changed

// File: rtl/fifo_write_controller.sv
// fifo_write_controller: write-side pointer, level, full/almost_full and overflow tracking for an async FIFO
module fifo_write_controller #(
  parameter int ADDR_WIDTH = 4,
  parameter int POINTER_WIDTH = ADDR_WIDTH + 1,
  parameter int ALMOST_FULL_LEVEL = 2 ** ADDR_WIDTH - 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic [POINTER_WIDTH-1:0] read_ptr_sync,
  input  logic                     overflow_clear,
  output logic [POINTER_WIDTH-1:0] write_ptr,
  output logic                     mem_write_en,
  output logic [ADDR_WIDTH-1:0]    mem_write_addr,
  output logic                     full,
  output logic                     almost_full,
  output logic [POINTER_WIDTH-1:0] level,
  output logic                     overflow,
  output logic                     overflow_sticky
);
  localparam logic [POINTER_WIDTH-1:0] FULL_CNT = POINTER_WIDTH'(1 << ADDR_WIDTH);
  localparam logic [POINTER_WIDTH-1:0] AF_CNT = POINTER_WIDTH'(ALMOST_FULL_LEVEL);
  logic accept, refuse;
  logic [POINTER_WIDTH-1:0] wp_next, diff;
  always_comb begin
    accept = write_en & ~full;
    refuse = write_en & full;
    wp_next = write_ptr + POINTER_WIDTH'(accept);
    diff = wp_next - read_ptr_sync;
  end
  assign mem_write_en = accept & ~reset;
  assign mem_write_addr = write_ptr[ADDR_WIDTH-1:0];
  // Flags come from the post-edge pointer, so a stale read pointer can only make them pessimistic
  always_ff @(posedge clk) begin
    if (reset) begin
      write_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      almost_full <= 1'b0;
      overflow <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      write_ptr <= wp_next;
      level <= diff;
      full <= diff == FULL_CNT;
      almost_full <= diff >= AF_CNT;
      overflow <= refuse;
      overflow_sticky <= refuse | (overflow_sticky & ~overflow_clear);
    end
  end
endmodule

// File: tb/tb_fifo_write_controller.sv
// tb_fifo_write_controller: scoreboard bench using unwrapped write/read counts as the reference
module tb_fifo_write_controller;
  logic clk = 0, reset = 1, write_en = 0, overflow_clear = 0;
  logic [4:0] read_ptr_sync = 0, write_ptr, level;
  logic [3:0] mem_write_addr;
  logic mem_write_en, full, almost_full, overflow, overflow_sticky;
  fifo_write_controller dut (
    .clk(clk), .reset(reset), .write_en(write_en), .read_ptr_sync(read_ptr_sync),
    .overflow_clear(overflow_clear), .write_ptr(write_ptr), .mem_write_en(mem_write_en),
    .mem_write_addr(mem_write_addr), .full(full), .almost_full(almost_full), .level(level),
    .overflow(overflow), .overflow_sticky(overflow_sticky)
  );
  always #5 clk = ~clk;
  typedef struct {int wp; int lvl; int f; int af; int ov; int st;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  int wr_cnt = 0, rd_cnt = 0, m_full = 0, m_st = 0;
  logic [4:0] occ;
  assign occ = write_ptr - read_ptr_sync;
  always @(negedge clk) if (!reset) assert (occ <= 5'd16) else $error("illegal read_ptr_sync %0d vs write_ptr %0d", read_ptr_sync, write_ptr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input int we, input int adv, input int oc, input int rst);
    exp_t e;
    int acc, lvl;
    rd_cnt += adv;
    write_en = we[0];
    overflow_clear = oc[0];
    reset = rst[0];
    read_ptr_sync = 5'(rd_cnt % 32);
    #1;
    acc = (we != 0 && m_full == 0 && rst == 0) ? 1 : 0;
    chk("mem_write_en", 32'(mem_write_en), 32'(acc));
    chk("mem_write_addr", 32'(mem_write_addr), 32'(wr_cnt % 16));
    if (rst != 0) begin
      e = '{0, 0, 0, 0, 0, 0};
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      wr_cnt += acc;
      lvl = wr_cnt - rd_cnt;
      e.wp = wr_cnt % 32;
      e.lvl = lvl;
      e.f = lvl == 16 ? 1 : 0;
      e.af = lvl >= 14 ? 1 : 0;
      e.ov = (we != 0 && m_full != 0) ? 1 : 0;
      e.st = (e.ov != 0 || (m_st != 0 && oc == 0)) ? 1 : 0;
    end
    m_full = e.f;
    m_st = e.st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("write_ptr", 32'(write_ptr), 32'(e.wp));
    chk("level", 32'(level), 32'(e.lvl));
    chk("full", 32'(full), 32'(e.f));
    chk("almost_full", 32'(almost_full), 32'(e.af));
    chk("overflow", 32'(overflow), 32'(e.ov));
    chk("overflow_sticky", 32'(overflow_sticky), 32'(e.st));
  endtask
  initial begin
    step(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0);
      if (i == 12) chk("af_before_14", 32'(almost_full), 32'd0);
      if (i == 13) chk("af_at_14", 32'(almost_full), 32'd1);
    end
    chk("fill_ptr", 32'(write_ptr), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk("ovf_ptr_hold", 32'(write_ptr), 32'd16);
      chk("ovf_pulse", 32'(overflow), 32'd1);
    end
    step(0, 0, 1, 0);
    chk("sticky_clear", 32'(overflow_sticky), 32'd0);
    chk("ovf_drop", 32'(overflow), 32'd0);
    step(1, 0, 1, 0);
    chk("sticky_set_wins", 32'(overflow_sticky), 32'd1);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    chk("full_release", 32'(full), 32'd0);
    step(1, 0, 0, 0);
    chk("refill_ptr", 32'(write_ptr), 32'd17);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("push_and_read_level", 32'(level), 32'd15);
    chk("push_and_read_full", 32'(full), 32'd0);
    while (wr_cnt < 31 || rd_cnt < 20)
      step(wr_cnt < 31 ? 1 : 0, (rd_cnt < 20 && rd_cnt < wr_cnt) ? 1 : 0, 0, 0);
    chk("pre_wrap_ptr", 32'(write_ptr), 32'd31);
    step(1, 0, 0, 0);
    chk("wrap_ptr", 32'(write_ptr), 32'd0);
    chk("wrap_addr", 32'(mem_write_addr), 32'd0);
    chk("wrap_level", 32'(level), 32'd12);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("pre_reset_level", 32'(level), 32'd9);
    step(1, 0, 0, 1);
    chk("reset_ptr", 32'(write_ptr), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    for (int i = 0; i < 300; i++)
      step(int'($urandom_range(0, 3) != 0), (rd_cnt < wr_cnt && $urandom_range(0, 2) == 0) ? 1 : 0,
           int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 99) == 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
